spi_edge_tx: RTL and testbench

- SPI slave transmitter: the MISO-direction counterpart of the existing SPI pixel receiver.
- Streams the stored edge-detected frame back to the MCU so it can be checked or logged.
- Reads 2-bit edge pixels from the frame SPRAM through a request/valid port and packs 4 pixels per byte, MSB-first.
- Shifts bytes out on sdo in SPI mode 0, with spiClk oversampled in the mainClk domain.

---
 rtl/spi_tx_pkg.sv | 42 ++++
 rtl/sync_edge_detect.sv | 36 +++
 rtl/spi_edge_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_edge_tx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the SPI edge-frame transmitter.
//   state_t      : transfer FSM states
//   *_DEF        : default frame geometry
//   put_pix()    : places a 2-bit pixel into its slot of the output byte
package spi_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    FULL,
    DRAIN
  } state_t;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  localparam int unsigned ADDR_W       = 19;
  localparam int unsigned X_W          = 10;
  localparam int unsigned Y_W          = 9;
  localparam int unsigned PIX_W        = 2;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned BIT_CNT_W    = 3;
  localparam int unsigned PIX_PER_BYTE = 4;
  localparam int unsigned PIX_CNT_W    = $clog2(PIX_PER_BYTE);

  // Pixel 0 of a byte occupies bits [7:6], pixel 3 occupies bits [1:0].
  function automatic logic [BYTE_W-1:0] put_pix(input logic [BYTE_W-1:0]    b,
                                                input logic [PIX_CNT_W-1:0] idx,
                                                input logic [PIX_W-1:0]     p);
    logic [BYTE_W-1:0] r;
    r = b;
    case (idx)
      2'd0:    r[7:6] = p;
      2'd1:    r[5:4] = p;
      2'd2:    r[3:2] = p;
      default: r[1:0] = p;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input with edge pulses.
//   clk, reset : sampling clock, synchronous active-high reset
//   din        : asynchronous input
//   level      : synchronized level
//   rise_c     : one-cycle pulse on a synchronized 0->1 transition
//   fall_c     : one-cycle pulse on a synchronized 1->0 transition
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Reset to 0 so a chip select held low through reset does not look like a new frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level  = sync_q[STAGES-1];
  assign rise_c = sync_q[STAGES-1] & ~prev_q;
  assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_edge_tx.sv
// SPI mode-0 slave transmitter streaming the stored edge frame to the MCU.
//   mainClk, reset : system clock, synchronous active-high reset
//   spiClk, ncs    : asynchronous SPI clock and chip select from the MCU
//   sdo            : MISO data, MSB first, changes after spiClk falls
//   rdAddr/rdReq   : SPRAM read port, {y,x} address, one-cycle request
//   rdData/rdValid : SPRAM read return, latency of one or more cycles
//   busy           : transfer active or read outstanding
//   frameDone      : pulse when the last pixel of the frame is fetched
//   underrun       : sticky, a byte boundary found no staged byte
module spi_edge_tx
  import spi_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              mainClk,
  input  logic              reset,
  input  logic              spiClk,
  input  logic              ncs,
  output logic              sdo,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rdReq,
  input  logic [PIX_W-1:0]  rdData,
  input  logic              rdValid,
  output logic              busy,
  output logic              frameDone,
  output logic              underrun
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic sync_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (mainClk),
    .reset  (reset),
    .din    (spiClk),
    .level  (sclk_level),
    .rise_c (sclk_rise),
    .fall_c (sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_ncs_sync (
    .clk    (mainClk),
    .reset  (reset),
    .din    (ncs),
    .level  (ncs_level),
    .rise_c (ncs_rise),
    .fall_c (ncs_fall)
  );

  // Mode 0 only needs the falling edge of the SPI clock.
  assign sync_unused = sclk_level ^ sclk_rise;

  state_t                state, state_d;
  logic [X_W-1:0]        x, x_d;
  logic [Y_W-1:0]        y, y_d;
  logic [BYTE_W-1:0]     stage, stage_d;
  logic [BYTE_W-1:0]     shreg, shreg_d;
  logic [PIX_CNT_W-1:0]  pix_cnt, pix_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic                  staged, staged_d;
  logic                  first_loaded, first_loaded_d;
  logic                  frame_end, frame_end_d;
  logic                  sdo_d, rd_req_d, busy_d, frame_done_d, underrun_d;
  logic [ADDR_W-1:0]     rd_addr_d;
  logic                  shift_fall;

  // Shift only inside an active transfer with chip select low.
  assign shift_fall = sclk_fall & ~ncs_level & (state != IDLE);

  // State and datapath registers.
  always_ff @(posedge mainClk) begin
    if (reset) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      stage        <= '0;
      shreg        <= '0;
      pix_cnt      <= '0;
      bit_cnt      <= '0;
      staged       <= 1'b0;
      first_loaded <= 1'b0;
      frame_end    <= 1'b0;
      sdo          <= 1'b0;
      rdReq        <= 1'b0;
      rdAddr       <= '0;
      busy         <= 1'b0;
      frameDone    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state        <= state_d;
      x            <= x_d;
      y            <= y_d;
      stage        <= stage_d;
      shreg        <= shreg_d;
      pix_cnt      <= pix_cnt_d;
      bit_cnt      <= bit_cnt_d;
      staged       <= staged_d;
      first_loaded <= first_loaded_d;
      frame_end    <= frame_end_d;
      sdo          <= sdo_d;
      rdReq        <= rd_req_d;
      rdAddr       <= rd_addr_d;
      busy         <= busy_d;
      frameDone    <= frame_done_d;
      underrun     <= underrun_d;
    end
  end

  // Next-state logic: shifter first, then fetch FSM, then chip-select abort on top.
  always_comb begin
    state_d        = state;
    x_d            = x;
    y_d            = y;
    stage_d        = stage;
    shreg_d        = shreg;
    pix_cnt_d      = pix_cnt;
    bit_cnt_d      = bit_cnt;
    staged_d       = staged;
    first_loaded_d = first_loaded;
    frame_end_d    = frame_end;
    rd_req_d       = 1'b0;
    busy_d         = busy;
    frame_done_d   = 1'b0;
    underrun_d     = underrun;

    // The first byte is loaded as soon as it is staged so bit 7 is ready before the first rise.
    if (staged && !first_loaded) begin
      shreg_d        = stage;
      staged_d       = 1'b0;
      first_loaded_d = 1'b1;
    end else if (shift_fall) begin
      if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) begin
        bit_cnt_d = '0;
        if (staged) begin
          shreg_d  = stage;
          staged_d = 1'b0;
        end else begin
          // Past the end of the frame the zero padding is expected, not an underrun.
          shreg_d = '0;
          if (!frame_end) begin
            underrun_d = 1'b1;
          end
        end
      end else begin
        shreg_d   = {shreg[BYTE_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt + BIT_CNT_W'(1);
      end
    end

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (ncs_fall) begin
          x_d            = '0;
          y_d            = '0;
          staged_d       = 1'b0;
          first_loaded_d = 1'b0;
          frame_end_d    = 1'b0;
          shreg_d        = '0;
          bit_cnt_d      = '0;
          pix_cnt_d      = '0;
          busy_d         = 1'b1;
          state_d        = FETCH;
        end
      end
      FETCH: begin
        rd_req_d = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (rdValid) begin
          stage_d   = put_pix(stage, pix_cnt, rdData);
          pix_cnt_d = pix_cnt + PIX_CNT_W'(1);
          if (x == X_W'(H_ACTIVE - 1)) begin
            x_d = '0;
            if (y == Y_W'(V_ACTIVE - 1)) begin
              y_d          = '0;
              frame_done_d = 1'b1;
              frame_end_d  = 1'b1;
            end else begin
              y_d = y + Y_W'(1);
            end
          end else begin
            x_d = x + X_W'(1);
          end
          if (pix_cnt == PIX_CNT_W'(PIX_PER_BYTE - 1)) begin
            staged_d = 1'b1;
            state_d  = FULL;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FULL: begin
        if (!staged && !frame_end) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // Swallow the read that was in flight when the transfer was aborted.
        if (rdValid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ncs_rise) begin
      shreg_d        = '0;
      bit_cnt_d      = '0;
      staged_d       = 1'b0;
      first_loaded_d = 1'b0;
      rd_req_d       = 1'b0;
      frame_done_d   = 1'b0;
      state_d        = (state == WAIT && !rdValid) ? DRAIN : IDLE;
    end

    // rdAddr always shows the next pixel to fetch; rdReq qualifies it.
    rd_addr_d = {y_d, x_d};
    sdo_d     = shreg_d[BYTE_W-1] & ~ncs_level;
  end

endmodule

// File: tb/tb_spi_edge_tx.sv
// Directed bench for spi_edge_tx with a variable-latency SPRAM model.
// The frame is shortened to two lines so a complete frame fits a short run
// while still exercising the x=639 line wrap.
module tb_spi_edge_tx;

  localparam int unsigned H = 640;
  localparam int unsigned V = 2;
  localparam int unsigned FRAME_BYTES = H * V / 4;

  logic        mainClk = 1'b0;
  logic        reset   = 1'b1;
  logic        spiClk  = 1'b0;
  logic        ncs     = 1'b1;
  logic [1:0]  rdData  = 2'd0;
  logic        rdValid = 1'b0;
  logic        sdo, rdReq, busy, frameDone, underrun;
  logic [18:0] rdAddr;

  int ncmp  = 0;
  int nfail = 0;

  // SPRAM model state
  int          lat   = 2;
  int          pend  = 0;
  int          pmode = 0;
  int          nreq  = 0;
  int          nfd   = 0;
  logic [18:0] paddr = '0;
  logic [18:0] alog[$];

  always #5 mainClk = ~mainClk;

  spi_edge_tx #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(2)) dut (
    .mainClk   (mainClk),
    .reset     (reset),
    .spiClk    (spiClk),
    .ncs       (ncs),
    .sdo       (sdo),
    .rdAddr    (rdAddr),
    .rdReq     (rdReq),
    .rdData    (rdData),
    .rdValid   (rdValid),
    .busy      (busy),
    .frameDone (frameDone),
    .underrun  (underrun)
  );

  // pmode 0: pixels 3,0,1,2 repeating -> 0xC6; pmode 1: x[1:0] -> 0x1B
  function automatic logic [1:0] pix(input logic [18:0] a);
    logic [1:0] xl;
    xl = a[1:0];
    return (pmode == 0) ? xl + 2'd3 : xl;
  endfunction

  // SPRAM: return data lat cycles after the request cycle
  always @(negedge mainClk) begin
    rdValid = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        rdValid = 1'b1;
        rdData  = pix(paddr);
      end
    end
    if (rdReq) begin
      pend  = lat;
      paddr = rdAddr;
      nreq  = nreq + 1;
      alog.push_back(rdAddr);
    end
    if (frameDone) nfd = nfd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One SPI byte at spiClk = mainClk/8, sampling sdo at each rising edge.
  task automatic spi_xfer(output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge mainClk);
      b = {b[6:0], sdo};
      spiClk = 1'b1;
      repeat (4) @(negedge mainClk);
      spiClk = 1'b0;
    end
  endtask

  task automatic do_reset();
    ncs = 1'b1;
    repeat (10) @(negedge mainClk);
    reset = 1'b1;
    repeat (3) @(negedge mainClk);
    reset = 1'b0;
    @(negedge mainClk);
  endtask

  initial begin
    logic [7:0] b;
    int bad, idx, n0;
    bit ok;

    // Reset values
    repeat (4) @(negedge mainClk);
    reset = 1'b0;
    @(negedge mainClk);
    chk("rst_sdo", sdo, 0);
    chk("rst_rdReq", rdReq, 0);
    chk("rst_rdAddr", rdAddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frameDone", frameDone, 0);
    chk("rst_underrun", underrun, 0);

    // Basic transfer: addresses 0..3, first bytes 0xC6
    pmode = 0;
    lat   = 2;
    alog.delete();
    ncs = 1'b0;
    repeat (40) @(negedge mainClk);
    chk("t1_busy", busy, 1);
    chk("t1_addr0", alog[0], 19'd0);
    chk("t1_addr1", alog[1], 19'd1);
    chk("t1_addr2", alog[2], 19'd2);
    chk("t1_addr3", alog[3], 19'd3);
    spi_xfer(b);
    chk("t1_byte0", b, 8'hC6);
    spi_xfer(b);
    chk("t1_byte1", b, 8'hC6);

    // Abort during byte 5 with a read outstanding, then restart
    lat = 10;
    do_reset();
    ncs = 1'b0;
    repeat (70) @(negedge mainClk);
    for (int i = 0; i < 5; i++) spi_xfer(b);
    chk("ab_byte4", b, 8'hC6);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge mainClk);
      spiClk = 1'b1;
      repeat (4) @(negedge mainClk);
      spiClk = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge mainClk);
      if (pend == lat) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ab_read_outstanding", ok, 1);
    @(negedge mainClk);
    ncs = 1'b1;
    n0  = nreq;
    repeat (5) @(negedge mainClk);
    chk("ab_busy_drain", busy, 1);
    repeat (30) @(negedge mainClk);
    chk("ab_busy_low", busy, 0);
    chk("ab_no_new_req", nreq, n0);
    chk("ab_sdo_idle", sdo, 0);
    idx = alog.size();
    ncs = 1'b0;
    repeat (70) @(negedge mainClk);
    chk("ab_restart_addr", alog[idx], 19'd0);
    spi_xfer(b);
    chk("ab_restart_byte0", b, 8'hC6);

    // Full (shortened) frame of 0x1B bytes, then zero padding
    lat   = 2;
    pmode = 1;
    do_reset();
    alog.delete();
    nreq = 0;
    nfd  = 0;
    ncs  = 1'b0;
    repeat (40) @(negedge mainClk);
    bad = 0;
    for (int i = 0; i < int'(FRAME_BYTES); i++) begin
      spi_xfer(b);
      if (b !== 8'h1B) bad++;
    end
    chk("fr_bad_bytes", bad, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      spi_xfer(b);
      if (b !== 8'h00) bad++;
    end
    chk("fr_bad_padding", bad, 0);
    chk("fr_frameDone_cnt", nfd, 1);
    chk("fr_underrun", underrun, 0);
    chk("fr_nreq", nreq, H * V);
    idx = 0;
    for (int i = 0; i < alog.size(); i++) begin
      if (alog[i] == 19'h0027F) idx = i;
    end
    chk("fr_line_wrap", alog[idx + 1], 19'h00400);
    chk("fr_rdAddr_wrap", rdAddr, 19'd0);

    // Slow SPRAM: second byte underruns and goes out as 0x00
    lat   = 40;
    pmode = 0;
    do_reset();
    ncs = 1'b0;
    repeat (200) @(negedge mainClk);
    chk("ur_before", underrun, 0);
    spi_xfer(b);
    chk("ur_byte0", b, 8'hC6);
    spi_xfer(b);
    chk("ur_byte1_zero", b, 8'h00);
    chk("ur_flag", underrun, 1);
    // Reset mid-transfer with a read outstanding
    reset = 1'b1;
    repeat (2) @(negedge mainClk);
    reset = 1'b0;
    @(negedge mainClk);
    n0 = nreq;
    repeat (60) @(negedge mainClk);
    chk("mr_no_req", nreq, n0);
    chk("mr_busy", busy, 0);
    chk("mr_underrun_clr", underrun, 0);
    chk("mr_sdo", sdo, 0);
    ncs = 1'b1;

    // spiClk activity with ncs high is ignored
    repeat (10) @(negedge mainClk);
    n0 = nreq;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      repeat (4) @(negedge mainClk);
      if (sdo !== 1'b0) ok = 1'b0;
      spiClk = 1'b1;
      repeat (4) @(negedge mainClk);
      spiClk = 1'b0;
    end
    chk("nh_sdo_low", ok, 1);
    chk("nh_no_req", nreq, n0);
    chk("nh_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
